// File: rtl/divide_control.sv
// divide_control: 8-bit unsigned restoring divider controller (shift/subtract FSM).
// Ports:
//   Clk      - system clock, rising edge
//   Reset    - synchronous active-low reset
//   Run      - start request, level-sensitive, sampled in IDLE
//   LoadB    - divisor load strobe, sampled in IDLE (wins over Run)
//   Din      - dividend on Run, divisor on LoadB
//   Aval     - remainder, low 8 bits of the 9-bit partial remainder A
//   Bval     - quotient Q
//   Sval     - divisor S
//   Busy     - high in LOAD, SHIFT and SUB
//   Done     - one-cycle completion pulse
//   DivZero  - divide-by-zero flag
// Build option: define DIV_ZERO_DETECT_EN to short-circuit S==0 straight to DONE
// with DivZero set; otherwise DivZero is 0 and S==0 runs the full loop.
module divide_control (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       LoadB,
    input  logic [7:0] Din,
    output logic [7:0] Aval,
    output logic [7:0] Bval,
    output logic [7:0] Sval,
    output logic       Busy,
    output logic       Done,
    output logic       DivZero
);
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, SUB, DONE, HOLD} state_t;

    state_t      state, state_n;
    logic [8:0]  a, a_n;
    logic [7:0]  q, q_n, s, s_n;
    logic [2:0]  cnt, cnt_n;
    logic [9:0]  diff;
`ifdef DIV_ZERO_DETECT_EN
    logic        div_zero, div_zero_n;
`endif

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
            a     <= '0;
            q     <= '0;
            s     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            a     <= a_n;
            q     <= q_n;
            s     <= s_n;
            cnt   <= cnt_n;
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    always_ff @(posedge Clk) begin
        if (!Reset) div_zero <= 1'b0;
        else        div_zero <= div_zero_n;
    end
    assign DivZero = div_zero;
`else
    assign DivZero = 1'b0;
`endif

    // diff[9] is the borrow: set when A < S
    assign diff = {1'b0, a} - {2'b00, s};

    always_comb begin
        state_n = state;
        a_n     = a;
        q_n     = q;
        s_n     = s;
        cnt_n   = cnt;
`ifdef DIV_ZERO_DETECT_EN
        div_zero_n = div_zero;
`endif
        case (state)
            IDLE: begin
                if (LoadB)    s_n     = Din;
                else if (Run) state_n = LOAD;
            end
            LOAD: begin
                a_n     = '0;
                q_n     = Din;
                cnt_n   = '0;
                state_n = SHIFT;
`ifdef DIV_ZERO_DETECT_EN
                div_zero_n = 1'b0;
                if (s == 8'd0) begin
                    a_n        = {1'b0, Din};
                    q_n        = 8'hFF;
                    div_zero_n = 1'b1;
                    state_n    = DONE;
                end
`endif
            end
            SHIFT: begin
                {a_n, q_n} = {a, q} << 1;
                state_n    = SUB;
            end
            SUB: begin
                if (!diff[9]) begin
                    a_n    = diff[8:0];
                    q_n[0] = 1'b1;
                end
                cnt_n   = cnt + 3'd1;
                state_n = (cnt == 3'd7) ? DONE : SHIFT;
            end
            DONE:    state_n = HOLD;
            HOLD:    state_n = Run ? HOLD : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Gated by Reset so both read 0 while reset is held, before the edge lands
    always_comb begin
        Busy = Reset && (state == LOAD || state == SHIFT || state == SUB);
        Done = Reset && (state == DONE);
    end

    assign Aval = a[7:0];
    assign Bval = q;
    assign Sval = s;
endmodule

// File: tb/tb_divide_control.sv
// tb_divide_control: directed scoreboard bench for divide_control.
module tb_divide_control;
    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Run = 1'b0;
    logic       LoadB = 1'b0;
    logic [7:0] Din = 8'd0;
    logic [7:0] Aval, Bval, Sval;
    logic       Busy, Done, DivZero;

    divide_control dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .LoadB(LoadB), .Din(Din),
        .Aval(Aval), .Bval(Bval), .Sval(Sval),
        .Busy(Busy), .Done(Done), .DivZero(DivZero)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [7:0] q;
        logic [7:0] a;
        logic       dz;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;

`ifdef DIV_ZERO_DETECT_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Load divisor, run one division, compare against the scoreboard entry.
    // poke: try to overwrite the divisor with 3 while busy.
    task automatic run_div(input logic [7:0] sv, input logic [7:0] dv, input bit poke);
        exp_t e;
        exp_t got;
        int n;
        Din = sv; LoadB = 1'b1; tick(); LoadB = 1'b0;
        check("sval_load", Sval, sv);
        if (sv == 8'd0) begin
            e.q = 8'hFF; e.a = dv; e.dz = DZ_EN; e.lat = DZ_EN ? 2 : 18;
        end else begin
            e.q = dv / sv; e.a = dv % sv; e.dz = 1'b0; e.lat = 18;
        end
        sb.push_back(e);
        Din = dv; Run = 1'b1; tick(); Run = 1'b0;
        n = 1;
        check("busy_load", Busy, 1'b1);
        while (!Done && n < 40) begin
            tick();
            n++;
            if (n == 3) Din = 8'hC3;
            if (poke && n == 4) begin LoadB = 1'b1; Din = 8'd3; end
            if (poke && n == 6) LoadB = 1'b0;
        end
        got = sb.pop_front();
        check("latency", n, got.lat);
        check("quotient", Bval, got.q);
        check("remainder", Aval, got.a);
        check("divzero", DivZero, got.dz);
        check("sval_kept", Sval, sv);
        tick();
        check("done_pulse", Done, 1'b0);
        check("q_hold", Bval, got.q);
        check("a_hold", Aval, got.a);
        tick();
    endtask

    initial begin
        int dones;
        int n;
        tick(); tick();
        check("rst_a", Aval, 8'd0);
        check("rst_b", Bval, 8'd0);
        check("rst_s", Sval, 8'd0);
        check("rst_busy", Busy, 1'b0);
        check("rst_done", Done, 1'b0);
        check("rst_dz", DivZero, 1'b0);
        Reset = 1'b1;
        tick();

        run_div(8'd7, 8'd100, 1'b0);
        run_div(8'd1, 8'd255, 1'b0);
        run_div(8'd9, 8'd5, 1'b0);
        run_div(8'd0, 8'h5A, 1'b0);
        run_div(8'd255, 8'd254, 1'b0);
        run_div(8'd3, 8'd3, 1'b0);
        run_div(8'd7, 8'd100, 1'b1);
        for (int i = 0; i < 4; i++)
            run_div(8'($urandom_range(1, 255)), 8'($urandom_range(0, 255)), 1'b0);

        // Run held high: exactly one division, then parked in HOLD
        Din = 8'd6; LoadB = 1'b1; tick(); LoadB = 1'b0;
        Din = 8'd50; Run = 1'b1;
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (Done) dones++;
        end
        check("hold_dones", dones, 1);
        check("hold_busy", Busy, 1'b0);
        check("hold_q", Bval, 8'd8);
        check("hold_a", Aval, 8'd2);
        Run = 1'b0;
        tick(); tick();

        // Reset mid-division at cycle t+8
        Din = 8'd7; LoadB = 1'b1; tick(); LoadB = 1'b0;
        Din = 8'd100; Run = 1'b1; tick(); Run = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        check("mid_busy", Busy, 1'b1);
        Reset = 1'b0;
        #1;
        check("rstin_busy", Busy, 1'b0);
        check("rstin_done", Done, 1'b0);
        tick();
        Reset = 1'b1;
        check("abort_a", Aval, 8'd0);
        check("abort_b", Bval, 8'd0);
        check("abort_s", Sval, 8'd0);
        check("abort_dz", DivZero, 1'b0);
        check("abort_busy", Busy, 1'b0);
        n = 0;
        for (int i = 0; i < 25; i++) begin
            if (Done) n++;
            tick();
        end
        check("abort_nodone", n, 0);
        check("abort_idle", Busy, 1'b0);

        run_div(8'd10, 8'd123, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
